// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_pkg
// Brief    : Shared depth, tag and entry types for the reorder buffer.
// Revision : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int TAG_W     = $clog2(ROB_DEPTH);
    localparam int c_preg_w  = 6;

    typedef logic [TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic                valid;
        logic                done;
        logic                has_rd;
        logic [c_preg_w-1:0] p_old_rd;
    } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Brief    : Two-wide dispatch / two-wide in-order commit ROB, 3 completion ports.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dispatch1_valid,
    input  logic                 dispatch1_has_rd,
    input  logic [5:0]           dispatch1_p_old_rd,
    input  logic                 dispatch2_valid,
    input  logic                 dispatch2_has_rd,
    input  logic [5:0]           dispatch2_p_old_rd,
    output logic                 dispatch_ready,
    output logic [TAG_W-1:0]     dispatch1_tag,
    output logic [TAG_W-1:0]     dispatch2_tag,
    input  logic [2:0]           complete_valid,
    input  logic [3*TAG_W-1:0]   complete_tag,
    output logic                 commit1_valid,
    output logic                 commit2_valid,
    output logic [5:0]           free_reg1,
    output logic [5:0]           free_reg2,
    output logic [TAG_W:0]       rob_count,
    output logic                 rob_empty
);
    import reorder_buffer_pkg::*;

    rob_entry_t          r_rob [ROB_DEPTH];
    logic [TAG_W-1:0]    r_head;
    logic [TAG_W-1:0]    r_tail;
    logic [TAG_W:0]      r_count;

    logic [TAG_W-1:0]    w_head_p1;
    logic                w_accept1;
    logic                w_accept2;
    logic                w_commit1;
    logic                w_commit2;
    logic [TAG_W:0]      w_n_disp;
    logic [TAG_W:0]      w_n_commit;
    logic [ROB_DEPTH-1:0] w_clr;
    logic [ROB_DEPTH-1:0] w_wr1;
    logic [ROB_DEPTH-1:0] w_wr2;
    logic [ROB_DEPTH-1:0] w_done_set;

    assign dispatch_ready = (r_count <= (TAG_W+1)'(ROB_DEPTH - 2));
    assign dispatch1_tag  = r_tail;
    assign dispatch2_tag  = r_tail + TAG_W'(1);
    assign rob_count      = r_count;
    assign rob_empty      = (r_count == '0);

    assign w_head_p1  = r_head + TAG_W'(1);
    assign w_accept1  = dispatch_ready & dispatch1_valid;
    assign w_accept2  = w_accept1 & dispatch2_valid;
    // Commit looks only at registered entry state, so same-edge completions never retire early.
    assign w_commit1  = r_rob[r_head].valid & r_rob[r_head].done;
    assign w_commit2  = w_commit1 & r_rob[w_head_p1].valid & r_rob[w_head_p1].done;
    assign w_n_disp   = {{TAG_W{1'b0}}, w_accept1} + {{TAG_W{1'b0}}, w_accept2};
    assign w_n_commit = {{TAG_W{1'b0}}, w_commit1} + {{TAG_W{1'b0}}, w_commit2};

    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
        assign w_clr[gi] = (w_commit1 && r_head == TAG_W'(gi)) ||
                           (w_commit2 && w_head_p1 == TAG_W'(gi));
        assign w_wr1[gi] = w_accept1 && (r_tail == TAG_W'(gi));
        assign w_wr2[gi] = w_accept2 && (dispatch2_tag == TAG_W'(gi));
        assign w_done_set[gi] =
            (complete_valid[0] && complete_tag[0*TAG_W +: TAG_W] == TAG_W'(gi)) ||
            (complete_valid[1] && complete_tag[1*TAG_W +: TAG_W] == TAG_W'(gi)) ||
            (complete_valid[2] && complete_tag[2*TAG_W +: TAG_W] == TAG_W'(gi));
    end

    // Dispatch targets are always free slots, so a write never collides with a retiring entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_rob[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (w_clr[i]) begin
                    r_rob[i] <= '0;
                end else if (w_wr1[i]) begin
                    r_rob[i] <= '{valid: 1'b1, done: 1'b0,
                                  has_rd: dispatch1_has_rd, p_old_rd: dispatch1_p_old_rd};
                end else if (w_wr2[i]) begin
                    r_rob[i] <= '{valid: 1'b1, done: 1'b0,
                                  has_rd: dispatch2_has_rd, p_old_rd: dispatch2_p_old_rd};
                end else if (w_done_set[i] && r_rob[i].valid) begin
                    r_rob[i].done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            commit1_valid <= 1'b0;
            commit2_valid <= 1'b0;
            free_reg1     <= '0;
            free_reg2     <= '0;
        end else begin
            r_head        <= r_head + w_n_commit[TAG_W-1:0];
            r_tail        <= r_tail + w_n_disp[TAG_W-1:0];
            r_count       <= r_count + w_n_disp - w_n_commit;
            commit1_valid <= w_commit1;
            commit2_valid <= w_commit2;
            free_reg1     <= (w_commit1 && r_rob[r_head].has_rd)    ? r_rob[r_head].p_old_rd    : '0;
            free_reg2     <= (w_commit2 && r_rob[w_head_p1].has_rd) ? r_rob[w_head_p1].p_old_rd : '0;
        end
    end

endmodule
`default_nettype wire
